// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op codes, FSM states and
// the effective B-operand MSB used for the overflow flag.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_DBL  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // op[3:2] selects the adder's B operand: B, ~B, A, or 0.
  function automatic logic eff_b_msb(input logic [1:0] bsel,
                                     input logic       a_msb,
                                     input logic       b_msb);
    case (bsel)
      2'b00:   return b_msb;
      2'b01:   return ~b_msb;
      2'b10:   return a_msb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/result bundle between a datapath core and the serial ALU.
interface alu_serial_if #(parameter int WIDTH = 16);

  logic             start;
  logic [3:0]       op;
  logic             right;
  logic [WIDTH-1:0] AI;
  logic [WIDTH-1:0] BI;
  logic             CI;
  logic             BCD;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] OUT;
  logic             CO;
  logic             V;
  logic             Z;
  logic             N;
  logic             HC;

  modport master (
    output start, op, right, AI, BI, CI, BCD,
    input  busy, done, OUT, CO, V, Z, N, HC
  );

  modport slave (
    input  start, op, right, AI, BI, CI, BCD,
    output busy, done, OUT, CO, V, Z, N, HC
  );

endinterface

// File: rtl/alu_digit.sv
// One 4-bit slice of the ALU: logic mux, binary adder and decimal correction.
module alu_digit
  import alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  input  logic [3:0] op_i,
  input  logic       bcd_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic       is_logic;
  logic [3:0] logic_res;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_c;
  logic [4:0] sum;

  always_comb begin
    is_logic  = (op_i[3:2] == 2'b11);
    logic_res = a_i;
    case ({2'b11, op_i[1:0]})
      OP_OR:   logic_res = a_i | b_i;
      OP_AND:  logic_res = a_i & b_i;
      OP_XOR:  logic_res = a_i ^ b_i;
      OP_PASS: logic_res = a_i;
      default: logic_res = a_i;
    endcase

    // Logic results pass through the adder with a zero B operand and no carry.
    add_a = is_logic ? logic_res : a_i;
    case (op_i[3:2])
      OP_ADD[3:2]: add_b = b_i;
      OP_SUB[3:2]: add_b = ~b_i;
      OP_DBL[3:2]: add_b = a_i;
      default:     add_b = 4'h0;
    endcase
    add_c = is_logic ? 1'b0 : carry_i;

    sum     = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c};
    digit_o = sum[3:0];
    carry_o = sum[4];

    if (bcd_i && (op_i == OP_ADD) && (sum > 5'd9)) begin
      digit_o = sum[3:0] + 4'd6;
      carry_o = 1'b1;
    end else if (bcd_i && (op_i == OP_SUB) && !sum[4]) begin
      digit_o = sum[3:0] - 4'd6;
      carry_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_serial.sv
// Nibble-serial ALU: one digit per RDY-enabled cycle, LSB digit first,
// with the inter-digit carry registered and a start/busy/done handshake.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RDY,
  alu_serial_if.slave bus
);

  localparam int NDIG  = WIDTH / 4;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             right_q, right_d;
  logic             ci_q, ci_d;
  logic             bcd_q, bcd_d;
  logic             carry_q, carry_d;
  logic             hc0_q, hc0_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             hc_q, hc_d;
  logic             ai_msb_q, ai_msb_d;
  logic             bop_msb_q, bop_msb_d;

  logic [CNT_W+1:0] bit_idx;
  logic [3:0]       dig_a;
  logic [3:0]       dig_b;
  logic [3:0]       add_dig;
  logic             add_co;
  logic [WIDTH-1:0] sh_vec;
  logic [3:0]       res_dig;
  logic             res_co;

  assign bit_idx = {cnt_q, 2'b00};
  assign dig_a   = a_q[bit_idx +: 4];
  assign dig_b   = b_q[bit_idx +: 4];
  assign sh_vec  = {ci_q, a_q[WIDTH-1:1]};

  alu_digit u_digit (
    .a_i     (dig_a),
    .b_i     (dig_b),
    .carry_i (carry_q),
    .op_i    (op_q),
    .bcd_i   (bcd_q),
    .digit_o (add_dig),
    .carry_o (add_co)
  );

  // Shift-right bypasses the adder; each digit is taken from the pre-shifted operand.
  assign res_dig = right_q ? sh_vec[bit_idx +: 4] : add_dig;
  assign res_co  = right_q ? 1'b0 : add_co;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    right_d   = right_q;
    ci_d      = ci_q;
    bcd_d     = bcd_q;
    carry_d   = carry_q;
    hc0_d     = hc0_q;
    work_d    = work_q;
    out_d     = out_q;
    co_d      = co_q;
    hc_d      = hc_q;
    ai_msb_d  = ai_msb_q;
    bop_msb_d = bop_msb_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          a_d     = bus.AI;
          b_d     = bus.BI;
          op_d    = bus.op;
          right_d = bus.right;
          ci_d    = bus.CI;
          bcd_d   = bus.BCD;
          carry_d = (bus.right || (bus.op[3:2] == 2'b11)) ? 1'b0 : bus.CI;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d[bit_idx +: 4] = res_dig;
        carry_d = res_co;
        if (cnt_q == '0) begin
          hc0_d = res_co;
        end
        if (cnt_q == LAST) begin
          out_d     = work_d;
          co_d      = right_q ? a_q[0] : res_co;
          hc_d      = hc0_q;
          ai_msb_d  = a_q[WIDTH-1];
          bop_msb_d = eff_b_msb(op_q[3:2], a_q[WIDTH-1], b_q[WIDTH-1]);
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      right_q   <= 1'b0;
      ci_q      <= 1'b0;
      bcd_q     <= 1'b0;
      carry_q   <= 1'b0;
      hc0_q     <= 1'b0;
      work_q    <= '0;
      out_q     <= '0;
      co_q      <= 1'b0;
      hc_q      <= 1'b0;
      ai_msb_q  <= 1'b0;
      bop_msb_q <= 1'b0;
    end else if (RDY) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      right_q   <= right_d;
      ci_q      <= ci_d;
      bcd_q     <= bcd_d;
      carry_q   <= carry_d;
      hc0_q     <= hc0_d;
      work_q    <= work_d;
      out_q     <= out_d;
      co_q      <= co_d;
      hc_q      <= hc_d;
      ai_msb_q  <= ai_msb_d;
      bop_msb_q <= bop_msb_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.OUT  = out_q;
  assign bus.CO   = co_q;
  assign bus.HC   = hc_q;
  assign bus.N    = out_q[WIDTH-1];
  assign bus.Z    = ~|out_q;
  assign bus.V    = ai_msb_q ^ bop_msb_q ^ co_q ^ out_q[WIDTH-1];

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=16): directed cases plus
// randomized operations against an arithmetic reference model.
module tb_alu_serial;
  import alu_pkg::*;

  localparam int W    = 16;
  localparam int NDIG = W / 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         co;
    logic         hc;
    logic         v;
  } res_t;

  logic CLK;
  logic RST_N;
  logic RDY;
  int   n_vec;
  int   n_err;
  logic [W-1:0] last_out;

  alu_serial_if #(.WIDTH(W)) bus ();

  alu_serial #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RDY   (RDY),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op, input logic right,
                                 input logic ci, input logic bcd);
    res_t         r;
    logic [W-1:0] bop;
    logic [W:0]   full;
    int           c;
    int           s;
    case (op[3:2])
      2'b00:   bop = b;
      2'b01:   bop = ~b;
      2'b10:   bop = a;
      default: bop = '0;
    endcase
    r = '0;
    if (right) begin
      r.out = {ci, a[W-1:1]};
      r.co  = a[0];
    end else if (op[3:2] == 2'b11) begin
      case (op[1:0])
        2'b00:   r.out = a | b;
        2'b01:   r.out = a & b;
        2'b10:   r.out = a ^ b;
        default: r.out = a;
      endcase
    end else if (bcd && (op == OP_ADD || op == OP_SUB)) begin
      c = int'(ci);
      for (int d = 0; d < NDIG; d++) begin
        s = int'(a[4*d +: 4]) + int'(bop[4*d +: 4]) + c;
        if (op == OP_ADD) begin
          if (s > 9) begin s = s + 6; c = 1; end
          else c = 0;
        end else begin
          if (s < 16) begin s = s - 6; c = 0; end
          else c = 1;
        end
        r.out[4*d +: 4] = 4'((s + 32) % 16);
        if (d == 0) r.hc = (c != 0);
      end
      r.co = (c != 0);
    end else begin
      full = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, ci};
      r.out = full[W-1:0];
      r.co  = full[W];
      r.hc  = (int'(a[3:0]) + int'(bop[3:0]) + int'(ci)) > 15;
    end
    r.v = a[W-1] ^ bop[W-1] ^ r.co ^ r.out[W-1];
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o,
                        input logic r, input logic c, input logic d,
                        input bit b2b, input int stall_at, input int stall_len,
                        input bit mid_start, input bit rnd_rdy);
    res_t e;
    int   lat;
    int   tot;
    int   stall_cnt;
    bit   stalled;
    bit   seen;
    bit   mid_done;
    e = model(a, b, o, r, c, d);
    if (!b2b) begin
      @(negedge CLK);
      check("done_pulse", bus.done, 1'b0);
    end
    RDY       = 1'b1;
    bus.AI    = a;
    bus.BI    = b;
    bus.op    = o;
    bus.right = r;
    bus.CI    = c;
    bus.BCD   = d;
    bus.start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    check("busy_acc", bus.busy, 1'b1);
    lat = 0; tot = 0; stall_cnt = 0; stalled = 0; seen = 0; mid_done = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK);
      tot++;
      if (RDY) lat++;
      @(negedge CLK);
      if (bus.done) begin
        seen = 1;
      end else begin
        check("busy_run", bus.busy, 1'b1);
        check("out_hold", bus.OUT, last_out);
        if (mid_start && lat == 1 && !mid_done) begin
          bus.start = 1'b1;
          bus.AI    = ~a;
          mid_done  = 1;
        end else begin
          bus.start = 1'b0;
        end
        if (rnd_rdy) begin
          RDY = ($urandom_range(0, 3) != 0);
        end else if (stall_at >= 0 && lat == stall_at && !stalled) begin
          RDY       = 1'b0;
          stalled   = 1;
          stall_cnt = stall_len;
        end else if (stall_cnt > 0) begin
          stall_cnt--;
          if (stall_cnt == 0) RDY = 1'b1;
        end
      end
    end
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
      RDY = 1'b1;
      return;
    end
    check("latency", lat, NDIG);
    if (!rnd_rdy) check("edges", tot, NDIG + stall_len);
    check("busy_done", bus.busy, 1'b0);
    check("OUT", bus.OUT, e.out);
    check("CO", bus.CO, e.co);
    check("HC", bus.HC, e.hc);
    check("V", bus.V, e.v);
    check("Z", bus.Z, e.out == '0);
    check("N", bus.N, e.out[W-1]);
    last_out = e.out;
  endtask

  initial begin
    n_vec = 0; n_err = 0; last_out = '0;
    RST_N = 1'b0; RDY = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.right = 1'b0;
    bus.AI = '0; bus.BI = '0; bus.CI = 1'b0; bus.BCD = 1'b0;
    #3;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_OUT", bus.OUT, 16'h0000);
    check("rst_CO", bus.CO, 1'b0);
    check("rst_HC", bus.HC, 1'b0);
    check("rst_V", bus.V, 1'b0);
    check("rst_Z", bus.Z, 1'b1);
    check("rst_N", bus.N, 1'b0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    run_op(16'h1234, 16'h0FCD, OP_ADD, 1'b0, 1'b0, 1'b0, 0, -1, 0, 0, 0);
    run_op(16'h0999, 16'h0001, OP_ADD, 1'b0, 1'b0, 1'b1, 0, -1, 0, 0, 0);
    run_op(16'h1000, 16'h0001, OP_SUB, 1'b0, 1'b1, 1'b1, 0, -1, 0, 0, 0);
    run_op(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 0, -1, 0, 0, 0);
    run_op(16'hF0F0, 16'h0F0F, OP_AND, 1'b0, 1'b0, 1'b0, 0, -1, 0, 0, 0);
    run_op(16'h8001, 16'h0000, OP_ADD, 1'b1, 1'b1, 1'b0, 0, -1, 0, 0, 0);
    run_op(16'h8001, 16'h1234, OP_DBL, 1'b0, 1'b0, 1'b0, 0, -1, 0, 0, 0);
    // stall after digit 1, start ignored mid-run, then back-to-back from DONE
    run_op(16'h4321, 16'h1111, OP_ADD, 1'b0, 1'b1, 1'b0, 0, 2, 3, 0, 0);
    run_op(16'hABCD, 16'h5555, OP_XOR, 1'b0, 1'b0, 1'b0, 0, -1, 0, 1, 0);
    run_op(16'h0F00, 16'h00F0, OP_OR,  1'b0, 1'b0, 1'b0, 1, -1, 0, 0, 0);

    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   ro;
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 4'($urandom_range(0, 15));
      run_op(ra, rb, ro, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0), -1, 0, 0, ($urandom_range(0, 2) == 0));
    end

    // reset while digit 2 is in progress
    @(negedge CLK);
    RDY = 1'b1;
    bus.AI = 16'h5A5A; bus.BI = 16'h1111; bus.op = OP_ADD;
    bus.right = 1'b0; bus.CI = 1'b0; bus.BCD = 1'b0;
    bus.start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_OUT", bus.OUT, 16'h0000);
    check("arst_Z", bus.Z, 1'b1);
    repeat (2) begin
      @(negedge CLK);
      check("arst_nodone", bus.done, 1'b0);
    end
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_idle", bus.done | bus.busy, 1'b0);
    end
    last_out = '0;
    run_op(16'h0123, 16'h0456, OP_ADD, 1'b0, 1'b0, 1'b1, 0, -1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, nibble-serial successor to the 8-bit single-cycle ALU.
- Processes WIDTH-bit operands one 4-bit digit per enabled cycle, LSB digit first, with the carry registered between digits.
- Supports binary and BCD add and subtract, logic ops, A+A and shift-right, with a start/busy/done handshake.
- Serves the wide-datapath core variants (16/24/32-bit accumulators) and honours the core-wide RDY stall.

Parameters:
- WIDTH, 16, operand width in bits; multiple of 4, minimum 8. Derived: NDIG = WIDTH/4.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RDY  in  1  global enable; when low, every register holds.
- start  in  1  request; operands, op and flags-in are sampled when accepted.
- op  in  4  0011 A+B, 0111 A-B, 1011 A+A, 1100 A|B, 1101 A&B, 1110 A^B, 1111 A.
- right  in  1  shift-right through carry; overrides op.
- AI  in  WIDTH  operand A.
- BI  in  WIDTH  operand B.
- CI  in  1  carry in; also the shift-in bit for right.
- BCD  in  1  decimal mode; affects 0011 and 0111 only.
- busy  out  1  high from acceptance until the done cycle.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- OUT  out  WIDTH  result, held until the next done.
- CO  out  1  carry out (borrow-not for subtract).
- V  out  1  signed overflow.
- Z  out  1  OUT == 0.
- N  out  1  OUT[WIDTH-1].
- HC  out  1  carry out of digit 0, after decimal correction.

Behaviour:
- Reset (async, RST_N low): state IDLE, digit counter 0, busy=0, done=0, OUT=0, CO=0, HC=0, internal AI_msb/BI_msb=0. Result: V=0, Z=1, N=0. Reset mid-operation aborts it; no done is produced.
- RDY low: state, counter, latched operands, outputs and done all hold, including a pending done pulse.
- FSM states: IDLE, RUN, DONE. All transitions require RDY=1.
- IDLE: start=1 latches AI, BI, op, right, CI, BCD; carry register := (right or op[3:2]==11) ? 0 : CI; counter := 0; next state RUN; busy=1.
- RUN: each cycle computes digit k = counter and writes OUT_work[4k+3:4k]; the carry register takes that digit's corrected carry.
- When k == NDIG-1: OUT, CO, HC and AI_msb/BI_msb (used for V) update together; state goes to DONE. Otherwise counter increments.
- DONE: done=1 and busy=0. start=1 here is accepted (back-to-back, same action as IDLE); otherwise go to IDLE.
- start while in RUN is ignored.
- Latency: start accepted at edge 0; done is high in the cycle after edge NDIG (RDY-high edges counted).
- B operand per op: 00 -> B, 01 -> ~B, 10 -> A (A+A), 11 -> 0.
- Logic/pass ops: the logic result feeds the adder with B-operand 0 and carry-in 0, so CO=0 and HC=0.
- Binary digit: s = a + b + c (5 bits); digit = s[3:0]; carry = s[4].
- BCD add (op 0011, BCD=1): if s > 9, digit = (s + 6) mod 16 and carry = 1.
- BCD subtract (op 0111, BCD=1): if s[4] == 0, digit = (s - 6) mod 16 and carry = 0.
- Shift-right: OUT = {CI, AI[WIDTH-1:1]}, CO = AI[0], HC = 0. Assembled digit-wise from the latched AI.
- Flags: N = OUT[WIDTH-1]; Z = ~|OUT; V = AI_msb ^ Bop_msb ^ CO ^ N, where Bop_msb is the effective B-operand MSB.
- Invalid op codes 0000-0010, 0100-0110 and 1000-1010 execute as the op with the same op[3:2] and op[1:0] semantics (binary-decoded); no error is raised.

Decomposition:
- Package alu_pkg: op encoding constants (OP_ADD, OP_SUB, OP_DBL, OP_OR, OP_AND, OP_XOR, OP_PASS) and FSM state encoding.
- One combinational sub-module, alu_digit:
  - inputs: 4-bit a, 4-bit b, carry, op, BCD;
  - outputs: 4-bit digit, carry out;
  - contains the logic mux, adder and decimal correction.
- Top level holds the FSM, counter, operand/result registers and flags.

Test Plan:
- WIDTH=16, op=0011, BCD=0, AI=0x1234, BI=0x0FCD, CI=0 -> OUT=0x2201, CO=0, Z=0; done exactly 4 cycles after start edge.
- op=0011, BCD=1, AI=0x0999, BI=0x0001, CI=0 -> OUT=0x1000, HC=1, CO=0. Then op=0111, BCD=1, AI=0x1000, BI=0x0001, CI=1 -> OUT=0x0999, CO=1.
- op=0011, BCD=0, AI=0x7FFF, BI=0x0001, CI=0 -> OUT=0x8000, V=1, N=1, CO=0. Then op=1101, AI=0xF0F0, BI=0x0F0F -> OUT=0x0000, Z=1, CO=0.
- right=1, AI=0x8001, CI=1 -> OUT=0xC000, CO=1, N=1. Also op=1011, AI=0x8001, CI=0 -> OUT=0x0002, CO=1.
- RDY low for 3 cycles after digit 1 of an add -> done delayed by exactly 3 cycles, OUT unchanged. start pulsed during RUN -> ignored. start in the DONE cycle -> second result 4 cycles later.
- RST_N low during digit 2 -> busy=0, done never pulses, OUT=0, Z=1 asynchronously. After release, a new start completes normally.
